qam16_deframer: RTL and testbench

QAM16_DEFRAMER -- requirements
Module: qam16_deframer

---
 rtl/qam16_deframer.sv | 164 ++++++++++++++++
 tb/tb_qam16_deframer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_deframer.sv
// QAM16 symbol-stream deframer: hunts for a 16-bit sync word, tracks frame lock
// with hit/miss hysteresis and emits payload bytes only while locked.
module qam16_deframer #(
    parameter logic [15:0] SYNC_WORD     = 16'hF628,
    parameter int          PAYLOAD_BYTES = 8,
    parameter int          LOCK_CNT      = 2,
    parameter int          MISS_CNT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_en,
    input  logic [3:0] nib,
    input  logic       nib_vld,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       sof,
    output logic       eof,
    output logic       locked,
    output logic       frame_err
);
    localparam int              NC_W     = $clog2(2 * PAYLOAD_BYTES);
    localparam logic [NC_W-1:0] LAST_NIB = NC_W'(2 * PAYLOAD_BYTES - 1);
    localparam logic [NC_W-1:0] HDR_LAST = NC_W'(3);
    localparam logic [2:0]      LOCK_TH  = 3'(LOCK_CNT);
    localparam logic [3:0]      MISS_TH  = 4'(MISS_CNT);

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    logic [1:0]      r_state;
    logic [11:0]     r_shift;     // three most recent nibbles; the fourth is the incoming one
    logic [2:0]      r_fill;
    logic [NC_W-1:0] r_nib_cnt;
    logic [3:0]      r_hi;
    logic [2:0]      r_hits;
    logic [2:0]      r_misses;
    logic            r_locked;
    logic [7:0]      r_byte_out;
    logic            r_byte_vld;
    logic            r_sof;
    logic            r_eof;
    logic            r_frame_err;

    logic            w_acc;
    logic            w_era;
    logic [15:0]     w_window;
    logic            w_sync;
    logic [2:0]      w_fill_nxt;
    logic [2:0]      w_hits_nxt;
    logic [3:0]      w_misses_nxt;
    logic            w_last;

    assign w_acc        = sym_en & nib_vld;
    assign w_era        = sym_en & ~nib_vld;
    assign w_window     = {r_shift, nib};
    assign w_sync       = (w_window == SYNC_WORD);
    assign w_fill_nxt   = (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
    assign w_hits_nxt   = (r_hits == 3'd7) ? 3'd7 : r_hits + 3'd1;
    assign w_misses_nxt = {1'b0, r_misses} + 4'd1;
    assign w_last       = (r_nib_cnt == LAST_NIB);

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_shift     <= '0;
            r_fill      <= '0;
            r_nib_cnt   <= '0;
            r_hi        <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
            r_locked    <= 1'b0;
            r_byte_out  <= '0;
            r_byte_vld  <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_era) begin
                // An erasure inside a frame is an error; in HUNT it only restarts the search.
                if (r_state != S_HUNT) r_frame_err <= 1'b1;
                r_state   <= S_HUNT;
                r_shift   <= '0;
                r_fill    <= '0;
                r_nib_cnt <= '0;
                r_hits    <= '0;
                r_misses  <= '0;
                r_locked  <= 1'b0;
            end else if (w_acc) begin
                case (r_state)
                    S_HUNT: begin
                        r_shift <= w_window[11:0];
                        r_fill  <= w_fill_nxt;
                        if (w_fill_nxt == 3'd4 && w_sync) begin
                            r_state   <= S_PAYLOAD;
                            r_nib_cnt <= '0;
                            r_hits    <= 3'd1;
                            r_misses  <= '0;
                            if (LOCK_CNT == 1) r_locked <= 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (!r_nib_cnt[0]) begin
                            r_hi <= nib;
                        end else if (r_locked) begin
                            r_byte_out <= {r_hi, nib};
                            r_byte_vld <= 1'b1;
                            r_sof      <= (r_nib_cnt == NC_W'(1));
                            r_eof      <= w_last;
                        end
                        if (w_last) begin
                            r_state   <= S_CHECK;
                            r_nib_cnt <= '0;
                        end else begin
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        r_shift <= w_window[11:0];
                        if (r_nib_cnt == HDR_LAST) begin
                            r_nib_cnt <= '0;
                            if (w_sync) begin
                                r_state  <= S_PAYLOAD;
                                r_hits   <= w_hits_nxt;
                                r_misses <= '0;
                                if (w_hits_nxt >= LOCK_TH) r_locked <= 1'b1;
                            end else if (r_locked && w_misses_nxt < MISS_TH) begin
                                // Flywheel: tolerate an isolated header miss while locked.
                                r_frame_err <= 1'b1;
                                r_state     <= S_PAYLOAD;
                                r_misses    <= w_misses_nxt[2:0];
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_HUNT;
                                r_shift     <= '0;
                                r_fill      <= '0;
                                r_hits      <= '0;
                                r_misses    <= '0;
                                r_locked    <= 1'b0;
                            end
                        end else begin
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign byte_out  = r_byte_out;
    assign byte_vld  = r_byte_vld;
    assign sof       = r_sof;
    assign eof       = r_eof;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_qam16_deframer.sv
// Self-checking bench for qam16_deframer: directed frame scenarios plus a randomized
// stream, all compared against a queue-based frame model.
module tb_qam16_deframer;
    localparam logic [15:0] SYNC = 16'hF628;
    localparam int          PB   = 8;
    localparam int          LK   = 2;
    localparam int          MS   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sym_en;
    logic [3:0] nib;
    logic       nib_vld;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       sof;
    logic       eof;
    logic       locked;
    logic       frame_err;

    qam16_deframer #(
        .SYNC_WORD    (SYNC),
        .PAYLOAD_BYTES(PB),
        .LOCK_CNT     (LK),
        .MISS_CNT     (MS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sym_en   (sym_en),
        .nib      (nib),
        .nib_vld  (nib_vld),
        .byte_out (byte_out),
        .byte_vld (byte_vld),
        .sof      (sof),
        .eof      (eof),
        .locked   (locked),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: nibble queues per frame section, plain integer counters.
    typedef enum {M_HUNT, M_PAYLOAD, M_CHECK} mstate_t;
    mstate_t    m_st;
    logic [3:0] m_win[$];
    logic [3:0] m_pay[$];
    logic [3:0] m_hdr[$];
    int         m_hits;
    int         m_misses;
    bit         m_locked;
    bit         e_vld, e_sof, e_eof, e_ferr;
    logic [7:0] e_byte;

    int n_bytes, n_sof, n_eof, n_ferr;

    function automatic void model_hunt();
        m_st = M_HUNT;
        m_win.delete();
        m_hits   = 0;
        m_misses = 0;
        m_locked = 0;
    endfunction

    function automatic void model_reset();
        model_hunt();
        e_vld  = 0;
        e_sof  = 0;
        e_eof  = 0;
        e_ferr = 0;
        e_byte = 8'h00;
    endfunction

    function automatic void model_step(input bit v, input logic [3:0] n);
        e_vld  = 0;
        e_sof  = 0;
        e_eof  = 0;
        e_ferr = 0;
        if (!v) begin
            if (m_st != M_HUNT) e_ferr = 1;
            model_hunt();
            return;
        end
        case (m_st)
            M_HUNT: begin
                m_win.push_back(n);
                if (m_win.size() > 4) void'(m_win.pop_front());
                if (m_win.size() == 4 && {m_win[0], m_win[1], m_win[2], m_win[3]} == SYNC) begin
                    m_st     = M_PAYLOAD;
                    m_pay.delete();
                    m_hits   = 1;
                    m_misses = 0;
                    if (LK == 1) m_locked = 1;
                end
            end
            M_PAYLOAD: begin
                m_pay.push_back(n);
                if (m_pay.size() % 2 == 0 && m_locked) begin
                    e_vld  = 1;
                    e_byte = {m_pay[m_pay.size() - 2], n};
                    e_sof  = (m_pay.size() == 2);
                    e_eof  = (m_pay.size() == 2 * PB);
                end
                if (m_pay.size() == 2 * PB) begin
                    m_st = M_CHECK;
                    m_hdr.delete();
                end
            end
            default: begin
                m_hdr.push_back(n);
                if (m_hdr.size() == 4) begin
                    if ({m_hdr[0], m_hdr[1], m_hdr[2], m_hdr[3]} == SYNC) begin
                        if (m_hits < 7) m_hits++;
                        m_misses = 0;
                        if (m_hits >= LK) m_locked = 1;
                        m_st = M_PAYLOAD;
                        m_pay.delete();
                    end else begin
                        e_ferr = 1;
                        m_misses++;
                        if (m_locked && m_misses < MS) begin
                            m_st = M_PAYLOAD;
                            m_pay.delete();
                        end else begin
                            model_hunt();
                        end
                    end
                end
            end
        endcase
    endfunction

    task automatic check_all(input string ph);
        check({ph, "_byte_vld"},  32'(byte_vld),  32'(e_vld));
        check({ph, "_byte_out"},  32'(byte_out),  32'(e_byte));
        check({ph, "_sof"},       32'(sof),       32'(e_sof));
        check({ph, "_eof"},       32'(eof),       32'(e_eof));
        check({ph, "_frame_err"}, 32'(frame_err), 32'(e_ferr));
        check({ph, "_locked"},    32'(locked),    32'(m_locked));
    endtask

    task automatic send_nib(input bit v, input logic [3:0] n, input int idle);
        sym_en  = 1'b1;
        nib_vld = v;
        nib     = n;
        model_step(v, n);
        @(posedge clk);
        #1;
        sym_en  = 1'b0;
        nib_vld = 1'b0;
        check_all("strobe");
        if (byte_vld)  n_bytes++;
        if (sof)       n_sof++;
        if (eof)       n_eof++;
        if (frame_err) n_ferr++;
        e_vld  = 0;
        e_sof  = 0;
        e_eof  = 0;
        e_ferr = 0;
        for (int i = 0; i < idle; i++) begin
            @(posedge clk);
            #1;
            check_all("idle");
        end
    endtask

    task automatic send_hdr(input logic [15:0] h);
        for (int i = 3; i >= 0; i--) send_nib(1'b1, h[i*4 +: 4], 1);
    endtask

    // Payload 01..08, nibble by nibble, high nibble first.
    task automatic send_pay_seq();
        logic [7:0] b;
        for (int i = 1; i <= PB; i++) begin
            b = 8'(i);
            send_nib(1'b1, b[7:4], 1);
            send_nib(1'b1, b[3:0], 1);
        end
    endtask

    task automatic send_frame(input logic [15:0] h);
        send_hdr(h);
        send_pay_seq();
    endtask

    task automatic clear_counts();
        n_bytes = 0;
        n_sof   = 0;
        n_eof   = 0;
        n_ferr  = 0;
    endtask

    initial begin
        logic [3:0]  pre[4];
        logic [15:0] h;
        logic [3:0]  r;

        rst     = 1'b1;
        sym_en  = 1'b0;
        nib     = 4'h0;
        nib_vld = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Prefix 2,F,6,2 must not false-match; three good frames lock on frame 2.
        pre = '{4'h2, 4'hF, 4'h6, 4'h2};
        for (int i = 0; i < 4; i++) send_nib(1'b1, pre[i], 1);
        send_hdr(SYNC);
        check("s1_lock_after_hdr1", 32'(locked), 32'd0);
        send_pay_seq();
        check("s1_bytes_frame1", 32'(n_bytes), 32'd0);
        send_hdr(SYNC);
        check("s1_lock_after_hdr2", 32'(locked), 32'd1);
        send_pay_seq();
        send_frame(SYNC);
        check("s1_bytes", 32'(n_bytes), 32'd16);
        check("s1_sof",   32'(n_sof),   32'd2);
        check("s1_eof",   32'(n_eof),   32'd2);

        // One corrupted header while locked: flywheel keeps the payload.
        clear_counts();
        send_frame(16'hF629);
        check("s2_ferr",   32'(n_ferr),  32'd1);
        check("s2_locked", 32'(locked),  32'd1);
        check("s2_bytes",  32'(n_bytes), 32'd8);
        send_frame(SYNC);
        send_frame(16'hF629);
        check("s2_misses_cleared", 32'(locked), 32'd1);
        send_frame(SYNC);

        // Two consecutive corrupted headers drop lock; two good headers relock.
        clear_counts();
        send_frame(16'hF629);
        send_hdr(16'hF629);
        check("s3_ferr",   32'(n_ferr), 32'd2);
        check("s3_locked", 32'(locked), 32'd0);
        send_pay_seq();
        send_frame(SYNC);
        check("s3_bytes_before_relock", 32'(n_bytes), 32'd8);
        send_frame(SYNC);
        check("s3_bytes_after_relock", 32'(n_bytes), 32'd16);

        // Erasure on payload nibble 5 of a locked frame.
        clear_counts();
        send_hdr(SYNC);
        send_nib(1'b1, 4'h0, 1);
        send_nib(1'b1, 4'h1, 1);
        send_nib(1'b1, 4'h0, 1);
        send_nib(1'b1, 4'h2, 1);
        send_nib(1'b0, 4'h0, 1);
        check("s4_bytes",  32'(n_bytes), 32'd2);
        check("s4_eof",    32'(n_eof),   32'd0);
        check("s4_ferr",   32'(n_ferr),  32'd1);
        check("s4_locked", 32'(locked),  32'd0);

        // Reset during frame-2 payload clears everything immediately.
        clear_counts();
        send_frame(SYNC);
        send_hdr(SYNC);
        send_nib(1'b1, 4'h0, 1);
        send_nib(1'b1, 4'h1, 1);
        send_nib(1'b1, 4'h0, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        clear_counts();
        send_frame(SYNC);
        check("s5_locked_one_hdr", 32'(locked),  32'd0);
        check("s5_bytes_one_hdr",  32'(n_bytes), 32'd0);
        send_frame(SYNC);
        check("s5_bytes_relock",   32'(n_bytes), 32'd8);

        // Randomized frames: corrupted headers, random payloads, sparse erasures, varying gaps.
        for (int f = 0; f < 40; f++) begin
            h = SYNC;
            if ($urandom_range(0, 99) < 20) h = SYNC ^ (16'h1 << $urandom_range(0, 15));
            for (int i = 3; i >= 0; i--) send_nib(1'b1, h[i*4 +: 4], $urandom_range(1, 3));
            for (int i = 0; i < 2 * PB; i++) begin
                r = 4'($urandom_range(0, 15));
                send_nib($urandom_range(0, 99) >= 2, r, $urandom_range(1, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
